// File: rtl/rr_dec_arbiter.sv
// rr_dec_arbiter: 4-requester round-robin arbiter with a 2-to-4 grant decoder.
// Each owner keeps the resource until it drops its request. Handoff to the next
// requester happens on the same edge, so there is no idle cycle between owners.
// Optional feature macro: ARB_TIMEOUT_EN. When it is defined, an owner that holds
// the grant for MAX_HOLD cycles while others wait is revoked and a one-cycle
// timeout pulse is raised. When it is undefined, there is no hold counter and
// timeout is tied low.
module rr_dec_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] ptr;
  logic [1:0] ptr_nxt;
  logic [1:0] idx_nxt;
  logic       vld_nxt;
  logic       timeout_nxt;
  logic       new_grant;
  logic [3:0] excl;
  logic [3:0] cand;
  logic [1:0] pos;
  logic [1:0] win_idx;
  logic       win_found;

  // The hold counter must be able to count up to MAX_HOLD-1, and a limit
  // below 2 would make the owner time out before holding at all.
  if (MAX_HOLD < 2 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_params
    $error("rr_dec_arbiter: MAX_HOLD must be >= 2 and below 2**CNT_W");
  end

  // Index to one-hot conversion that forms the grant vector.
  function automatic logic [3:0] decode(input logic [1:0] idx);
    logic [3:0] onehot;
    onehot      = 4'b0000;
    onehot[idx] = 1'b1;
    return onehot;
  endfunction

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_nxt;
  logic             at_limit;

  // The owner has used up its slot once the counter reaches MAX_HOLD-1
  // while it is still requesting.
  assign at_limit = (state == GRANT) && req[gnt_idx] &&
                    (hold_cnt >= CNT_W'(MAX_HOLD - 1));

  // An owner whose slot expired is left out of the search so that the
  // winner, if any, is always a different requester.
  assign excl = at_limit ? decode(gnt_idx) : 4'b0000;
`else
  // Without the timeout feature nobody is ever excluded from the search.
  assign excl = 4'b0000;
`endif

  assign cand = req & ~excl;

  // Round-robin search starting at ptr and wrapping mod 4; the first
  // candidate found in that order wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    pos       = ptr;
    for (int i = 0; i < 4; i++) begin
      pos = ptr + 2'(i);
      if (!win_found && cand[pos]) begin
        win_found = 1'b1;
        win_idx   = pos;
      end
    end
  end

  // Next-state and next-output logic. A new grant always moves ptr just past
  // the winner, so a released owner ranks last at the next search.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    idx_nxt     = gnt_idx;
    vld_nxt     = gnt_vld;
    timeout_nxt = 1'b0;
    new_grant   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_nxt    = hold_cnt;
`endif

    case (state)
      IDLE: begin
        if (win_found) begin
          new_grant = 1'b1;
        end
      end
      GRANT: begin
        if (req[gnt_idx]) begin
`ifdef ARB_TIMEOUT_EN
          if (at_limit) begin
            if (win_found) begin
              new_grant   = 1'b1;
              timeout_nxt = 1'b1;
            end else begin
              hold_nxt = '0;
            end
          end else begin
            hold_nxt = hold_cnt + 1'b1;
          end
`endif
        end else if (win_found) begin
          new_grant = 1'b1;
        end else begin
          state_nxt = IDLE;
          vld_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        vld_nxt   = 1'b0;
      end
    endcase

    if (new_grant) begin
      state_nxt = GRANT;
      ptr_nxt   = win_idx + 2'd1;
      idx_nxt   = win_idx;
      vld_nxt   = 1'b1;
`ifdef ARB_TIMEOUT_EN
      hold_nxt  = '0;
`endif
    end
  end

  // State, pointer and registered outputs; the grant vector is decoded from
  // the next owner index so it is never out of step with gnt_idx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      gnt_idx <= 2'd0;
      gnt_vld <= 1'b0;
      gnt     <= 4'b0000;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt_idx <= idx_nxt;
      gnt_vld <= vld_nxt;
      gnt     <= vld_nxt ? decode(idx_nxt) : 4'b0000;
      timeout <= timeout_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Consecutive-cycle counter for the current owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// tb_rr_dec_arbiter: directed test of the round-robin arbiter with hand-computed
// expectations; handles both the default build and ARB_TIMEOUT_EN builds.
module tb_rr_dec_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int err_count   = 0;
  int check_count = 0;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_STEPS = 3;
`else
  localparam int HOLD_STEPS = 10;
`endif

  rr_dec_arbiter #(
    .MAX_HOLD(4),
    .CNT_W   (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .gnt_vld(gnt_vld),
    .timeout(timeout)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] r);
    req = r;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] e_gnt,
                             input logic [1:0] e_idx, input logic e_vld,
                             input logic e_to);
    logic [3:0] onehot;
    check_count++;
    assert (gnt === e_gnt) else begin
      err_count++;
      $error("[TB] FAIL %s gnt observed=%b expected=%b", tag, gnt, e_gnt);
    end
    check_count++;
    assert (gnt_idx === e_idx) else begin
      err_count++;
      $error("[TB] FAIL %s gnt_idx observed=%0d expected=%0d", tag, gnt_idx, e_idx);
    end
    check_count++;
    assert (gnt_vld === e_vld) else begin
      err_count++;
      $error("[TB] FAIL %s gnt_vld observed=%b expected=%b", tag, gnt_vld, e_vld);
    end
    check_count++;
    assert (timeout === e_to) else begin
      err_count++;
      $error("[TB] FAIL %s timeout observed=%b expected=%b", tag, timeout, e_to);
    end
    onehot = 4'b0000;
    if (gnt_vld === 1'b1) onehot[gnt_idx] = 1'b1;
    check_count++;
    assert (gnt === onehot) else begin
      err_count++;
      $error("[TB] FAIL %s onehot observed=%b expected=%b", tag, gnt, onehot);
    end
  endtask

  initial begin
    // Reset held with every request high: nothing may be granted.
    rst = 1'b1;
    applyStimulus(4'b1111);
    stepClock();
    checkOutput("reset_a", 4'b0000, 2'd0, 1'b0, 1'b0);
    stepClock();
    checkOutput("reset_b", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(4'b0000);
    stepClock();
    checkOutput("idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester grant and release; gnt_idx keeps the last owner.
    applyStimulus(4'b0100);
    stepClock();
    checkOutput("single_gnt", 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0000);
    stepClock();
    checkOutput("single_rel", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Owner 1 holds while requester 3 waits, then hands off directly.
    applyStimulus(4'b0010);
    stepClock();
    checkOutput("hold_gnt", 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(4'b1010);
    for (int i = 0; i < HOLD_STEPS; i++) begin
      stepClock();
      checkOutput("hold_keep", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    applyStimulus(4'b1000);
    stepClock();
    checkOutput("hold_handoff", 4'b1000, 2'd3, 1'b1, 1'b0);

    // Asynchronous reset mid-grant clears outputs before any clock edge.
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    stepClock();
    checkOutput("rst_held", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(4'b1111);
    stepClock();
    checkOutput("rst_ptr0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Rotation with bubble-free handoffs and wrap back to requester 0.
    applyStimulus(4'b1110);
    stepClock();
    checkOutput("rot_1", 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(4'b1101);
    stepClock();
    checkOutput("rot_2", 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b1011);
    stepClock();
    checkOutput("rot_3", 4'b1000, 2'd3, 1'b1, 1'b0);
    applyStimulus(4'b0111);
    stepClock();
    checkOutput("rot_wrap", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Move the pointer back to 0, then go idle.
    applyStimulus(4'b1000);
    stepClock();
    checkOutput("to_3", 4'b1000, 2'd3, 1'b1, 1'b0);
    applyStimulus(4'b0000);
    stepClock();
    checkOutput("to_idle", 4'b0000, 2'd3, 1'b0, 1'b0);

    // Long hold by owner 0 while owner 1 waits.
    applyStimulus(4'b0011);
    stepClock();
    checkOutput("to_gnt0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      stepClock();
      checkOutput("to_hold0", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    stepClock();
`ifdef ARB_TIMEOUT_EN
    checkOutput("to_revoke", 4'b0010, 2'd1, 1'b1, 1'b1);
    stepClock();
    checkOutput("to_pulse_end", 4'b0010, 2'd1, 1'b1, 1'b0);
`else
    checkOutput("to_none", 4'b0001, 2'd0, 1'b1, 1'b0);
    stepClock();
    checkOutput("to_none_b", 4'b0001, 2'd0, 1'b1, 1'b0);
`endif

    // Lone requester is never revoked and never sees a pulse.
    applyStimulus(4'b0001);
    stepClock();
    checkOutput("alone_gnt", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      stepClock();
      checkOutput("alone_keep", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    applyStimulus(4'b0000);
    stepClock();
    checkOutput("final_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
